// File: rtl/sine_dds_pkg.sv
// -----------------------------------------------------------------------------
// sine_dds_pkg
// Shared types and default parameters for the sine DDS front end.
//   quadrant_t   : which quarter of the sine period the phase sits in
//   DEF_PHASE_W  : default phase accumulator / tuning word width
//   DEF_ADDRW    : default quarter-wave ROM address width
//   DEF_WIDTH    : default ROM magnitude width
// -----------------------------------------------------------------------------
package sine_dds_pkg;

  localparam int DEF_PHASE_W = 16;
  localparam int DEF_ADDRW   = 8;
  localparam int DEF_WIDTH   = 8;

  // Top two phase bits. Odd quadrants walk the quarter-wave table backwards,
  // the upper half of the period is negated.
  typedef enum logic [1:0] {
    Q0_RISE     = 2'd0,
    Q1_FALL     = 2'd1,
    Q2_NEG_FALL = 2'd2,
    Q3_NEG_RISE = 2'd3
  } quadrant_t;

endpackage : sine_dds_pkg

// File: rtl/dds_phase_acc.sv
// -----------------------------------------------------------------------------
// dds_phase_acc
// Phase accumulator with a loadable tuning word.
//   clk, rst   : clock, synchronous active-high reset
//   en         : add the tuning word to the phase this cycle
//   clr        : force phase to zero (beats en, does not touch ftw)
//   ftw_load   : capture ftw_in; the new word is used from the next cycle on
//   ftw_in     : new tuning word
//   phase_msb  : top ADDRW+2 phase bits (quadrant + ROM index)
//   wrap       : registered carry-out of the accumulation
// -----------------------------------------------------------------------------
module dds_phase_acc #(
  parameter int PHASE_W = sine_dds_pkg::DEF_PHASE_W,
  parameter int ADDRW   = sine_dds_pkg::DEF_ADDRW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clr,
  input  logic               ftw_load,
  input  logic [PHASE_W-1:0] ftw_in,
  output logic [ADDRW+1:0]   phase_msb,
  output logic               wrap
);

  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] ftw;
  logic [PHASE_W:0]   sum;

  // One extra bit captures the carry that marks a full period.
  assign sum = {1'b0, phase} + {1'b0, ftw};

  // NOTE: state is updated with non-blocking assignments so every register
  // sees the pre-edge value of the others (en uses the old ftw on a load).
  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= '0;
      ftw   <= '0;
      wrap  <= 1'b0;
    end else begin
      if (ftw_load) begin
        ftw <= ftw_in;
      end
      if (clr) begin
        phase <= '0;
        wrap  <= 1'b0;
      end else if (en) begin
        phase <= sum[PHASE_W-1:0];
        wrap  <= sum[PHASE_W];
      end else begin
        wrap  <= 1'b0;
      end
    end
  end

  // Bits below the ROM index are truncation only and never leave this block.
  assign phase_msb = phase[PHASE_W-1 -: ADDRW+2];

endmodule : dds_phase_acc

// File: rtl/sine_dds.sv
// -----------------------------------------------------------------------------
// sine_dds
// DDS front end: accumulates phase, folds it onto a quarter-wave ROM and
// produces a registered signed full-wave sine sample.
//   clk, rst     : clock, synchronous active-high reset
//   en           : advance phase and emit one sample
//   clr          : synchronous phase clear (priority over en)
//   ftw_load     : load ftw_in as the new phase increment
//   ftw_in       : tuning word
//   rom_addr     : quarter-wave ROM address, combinational from phase
//   rom_data     : ROM magnitude, same-cycle asynchronous read
//   sample       : signed WIDTH+1 bit sine sample, registered
//   sample_valid : sample updated on this cycle
//   wrap         : accumulator carried out on the step that made this sample
// -----------------------------------------------------------------------------
module sine_dds
  import sine_dds_pkg::*;
#(
  parameter int PHASE_W = DEF_PHASE_W,
  parameter int ADDRW   = DEF_ADDRW,
  parameter int WIDTH   = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clr,
  input  logic               ftw_load,
  input  logic [PHASE_W-1:0] ftw_in,
  output logic [ADDRW-1:0]   rom_addr,
  input  logic [WIDTH-1:0]   rom_data,
  output logic signed [WIDTH:0] sample,
  output logic               sample_valid,
  output logic               wrap
);

  logic [ADDRW+1:0] phase_msb;
  quadrant_t        quad;
  logic [ADDRW-1:0] idx;
  logic             mirror;
  logic             negative;
  logic [WIDTH:0]   mag;

  dds_phase_acc #(
    .PHASE_W (PHASE_W),
    .ADDRW   (ADDRW)
  ) u_acc (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .clr       (clr),
    .ftw_load  (ftw_load),
    .ftw_in    (ftw_in),
    .phase_msb (phase_msb),
    .wrap      (wrap)
  );

  // Fold the current (pre-update) phase onto the quarter-wave table.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    quad     = quadrant_t'(phase_msb[ADDRW+1 -: 2]);
    idx      = phase_msb[ADDRW-1:0];
    mirror   = 1'b0;
    negative = 1'b0;
    case (quad)
      Q0_RISE:     ;
      Q1_FALL:     mirror = 1'b1;
      Q2_NEG_FALL: negative = 1'b1;
      Q3_NEG_RISE: begin
        mirror   = 1'b1;
        negative = 1'b1;
      end
      default:     ;
    endcase
    rom_addr = mirror ? ~idx : idx;
  end

  // Magnitude never exceeds 2^WIDTH-1, so negation in WIDTH+1 bits is safe.
  assign mag = {1'b0, rom_data};

  always_ff @(posedge clk) begin
    if (rst) begin
      sample       <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= en;
      if (en) begin
        sample <= negative ? $signed(-mag) : $signed(mag);
      end
    end
  end

endmodule : sine_dds

// File: tb/tb_sine_dds.sv
// -----------------------------------------------------------------------------
// tb_sine_dds
// Self-checking bench for sine_dds (PHASE_W=16, ADDRW=8, WIDTH=8).
// The external ROM is a table filled from the quarter-wave formula; the
// reference model computes the expected full-wave sample straight from
// sin() of the truncated phase, independent of any folding.
// -----------------------------------------------------------------------------
module tb_sine_dds;

  localparam int PW = 16;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam real PI = 3.14159265358979323846;

  logic          clk = 1'b0;
  logic          rst, en, clr, ftw_load;
  logic [PW-1:0] ftw_in;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic signed [DW:0] sample;
  logic          sample_valid, wrap;

  logic [DW-1:0] rom [2**AW];

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  // Reference model state.
  int m_phase, m_ftw, m_sample;
  bit m_valid, m_wrap;

  always #5 clk = ~clk;

  sine_dds #(.PHASE_W(PW), .ADDRW(AW), .WIDTH(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .clr          (clr),
    .ftw_load     (ftw_load),
    .ftw_in       (ftw_in),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .sample       (sample),
    .sample_valid (sample_valid),
    .wrap         (wrap)
  );

  assign rom_data = rom[rom_addr];

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Full-wave sine of the truncated phase: 1024 points per period,
  // sampled at half-step offsets, magnitude rounded to 8 bits.
  function automatic int model_sample(input int ph);
    int  k;
    real s;
    int  m;
    k = ph >> (PW - AW - 2);
    s = $sin((real'(k) + 0.5) * 2.0 * PI / real'(2 ** (AW + 2)));
    m = $rtoi(255.0 * ((s < 0.0) ? -s : s) + 0.5);
    return (s < 0.0) ? -m : m;
  endfunction

  // Rising quarter: index grows with phase; falling quarter: it shrinks.
  function automatic int model_addr(input int ph);
    int k;
    k = (ph >> (PW - AW - 2)) % 1024;
    return ((k / 256) % 2 == 1) ? 255 - (k % 256) : (k % 256);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_phase  <= 0;
      m_ftw    <= 0;
      m_sample <= 0;
      m_valid  <= 1'b0;
      m_wrap   <= 1'b0;
    end else begin
      if (en) m_sample <= model_sample(m_phase);
      m_valid <= en;
      if (clr) begin
        m_phase <= 0;
        m_wrap  <= 1'b0;
      end else if (en) begin
        m_phase <= (m_phase + m_ftw) % 65536;
        m_wrap  <= (m_phase + m_ftw) > 65535;
      end else begin
        m_wrap  <= 1'b0;
      end
      if (ftw_load) m_ftw <= int'(ftw_in);
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("sample", sample, m_sample);
      check("sample_valid", {31'b0, sample_valid}, {31'b0, m_valid});
      check("wrap", {31'b0, wrap}, {31'b0, m_wrap});
      check("rom_addr", {24'b0, rom_addr}, model_addr(m_phase));
    end
  end

  task automatic step(input logic e, input logic c, input logic l,
                      input logic [PW-1:0] f);
    rst      = 1'b0;
    en       = e;
    clr      = c;
    ftw_load = l;
    ftw_in   = f;
    @(negedge clk);
  endtask

  initial begin
    int nw, wc;
    for (int i = 0; i < 2 ** AW; i++)
      rom[i] = DW'($rtoi(255.0 * $sin((real'(i) + 0.5) * PI / 512.0) + 0.5));

    // Pin the model to hand-computed values.
    check("model_k0", model_sample(16'h0000), 1);
    check("model_k255", model_sample(16'h3FC0), 255);
    check("model_k512", model_sample(16'h8000), -1);
    check("model_k72", model_sample(16'h1234), 110);
    check("model_addr_q1", model_addr(16'h4000), 255);

    // 1. Reset held with en and a pending load.
    rst = 1'b1; en = 1'b1; clr = 1'b0; ftw_load = 1'b1; ftw_in = 16'h0040;
    repeat (3) begin
      @(negedge clk);
      chk_on = 1'b1;
      check("rst_sample", sample, 0);
      check("rst_valid", {31'b0, sample_valid}, 0);
      check("rst_addr", {24'b0, rom_addr}, 0);
    end

    // 2. Full-wave sweep.
    step(1'b0, 1'b0, 1'b1, 16'h0040);
    nw = 0;
    wc = 0;
    for (int i = 1; i <= 1024; i++) begin
      step(1'b1, 1'b0, 1'b0, 16'h0000);
      if (wrap) begin
        nw++;
        wc = i;
      end
      if (i == 1)   check("sweep_first", sample, 1);
      if (i == 1)   check("sweep_addr1", {24'b0, rom_addr}, 1);
      if (i == 256) check("sweep_peak", sample, 255);
      if (i == 256) check("sweep_addr_mirror", {24'b0, rom_addr}, 255);
      if (i == 512) check("sweep_halfend", sample, 1);
      if (i == 513) check("sweep_neg", sample, -1);
    end
    check("sweep_wrap_count", nw, 1);
    check("sweep_wrap_cycle", wc, 1024);

    // 3. Wrap in the middle of a large tuning word.
    step(1'b0, 1'b0, 1'b1, 16'hC000);
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    check("wrap_step1", {31'b0, wrap}, 0);
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    check("wrap_step2", {31'b0, wrap}, 1);
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    check("wrap_step3", {31'b0, wrap}, 1);
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    check("wrap_step4", {31'b0, wrap}, 1);
    check("wrap_step4_addr", {24'b0, rom_addr}, 0);

    // 4. Clear beats en; a same-cycle load still lands.
    step(1'b0, 1'b0, 1'b1, 16'h1234);
    step(1'b1, 1'b0, 1'b1, 16'h0040);
    check("clr_pre_addr", {24'b0, rom_addr}, 72);
    step(1'b1, 1'b1, 1'b0, 16'h0000);
    check("clr_sample", sample, 110);
    check("clr_valid", {31'b0, sample_valid}, 1);
    check("clr_wrap", {31'b0, wrap}, 0);
    check("clr_addr", {24'b0, rom_addr}, 0);

    // 5. New tuning word takes effect one step late.
    step(1'b1, 1'b0, 1'b1, 16'h0100);
    check("ftw_old_step", {24'b0, rom_addr}, 1);
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    check("ftw_new_step", {24'b0, rom_addr}, 5);

    // 6. en gaps.
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    check("gap_valid0", {31'b0, sample_valid}, 1);
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    check("gap_valid1", {31'b0, sample_valid}, 0);
    check("gap_hold_addr1", {24'b0, rom_addr}, 9);
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    check("gap_valid2", {31'b0, sample_valid}, 0);
    check("gap_hold_addr2", {24'b0, rom_addr}, 9);
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    check("gap_valid3", {31'b0, sample_valid}, 1);
    check("gap_addr3", {24'b0, rom_addr}, 13);
    check("gap_wrap", {31'b0, wrap}, 0);

    // Mid-operation reset with en held high.
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_valid", {31'b0, sample_valid}, 0);
    check("midrst_sample", sample, 0);
    check("midrst_addr", {24'b0, rom_addr}, 0);
    @(negedge clk);
    check("midrst_valid2", {31'b0, sample_valid}, 0);

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_sine_dds

// File: doc/sine_dds.md
# sine_dds

Direct digital synthesis front end for the sine generator. It accumulates a programmable phase increment, folds the phase into a quarter-wave ROM address, and drives an external asynchronous-read ROM. It takes the ROM's combinational magnitude back in the same cycle and emits a registered, signed, full-wave sine sample.

## Interface
- PHASE_W, 16: phase accumulator and tuning word width; must be ≥ ADDRW+2.
- ADDRW, 8: ROM address width; the ROM holds 2^ADDRW quarter-wave entries.
- WIDTH, 8: ROM data width, unsigned magnitude.
- clk  in  1: single clock, all state on rising edge.
- rst  in  1: synchronous, active-high reset.
- en  in  1: advance phase and produce one sample this cycle.
- clr  in  1: synchronous phase clear.
- ftw_load  in  1: load the tuning word.
- ftw_in  in  PHASE_W: new tuning word (phase increment).
- rom_addr  out  ADDRW: address to the ROM, combinational from the phase register.
- rom_data  in  WIDTH: ROM magnitude, valid in the same cycle as rom_addr.
- sample  out  WIDTH+1: signed two's-complement sine sample, registered.
- sample_valid  out  1: sample updated this cycle, registered.
- wrap  out  1: one-cycle pulse when the accumulator carried out, registered.

## Operation
- **State:** phase[PHASE_W-1:0] and ftw[PHASE_W-1:0].
- **Tuning word:** ftw_load=1 captures ftw_in into ftw. It is first used on the next cycle's accumulation. A simultaneous en uses the old ftw.
- **Accumulation:** en=1 and clr=0 gives phase <= phase + ftw, modulo 2^PHASE_W. wrap <= carry-out of that add. Otherwise wrap <= 0.
- **Clear:** clr=1 gives phase <= 0 and wrap <= 0, regardless of en. ftw is unaffected, and an ftw_load in the same cycle still takes effect.
- **Priority:** rst > clr > en.
- **Folding:**
  - quadrant q = phase[PHASE_W-1:PHASE_W-2]
  - idx = phase[PHASE_W-3 -: ADDRW]
  - rom_addr = q[0] ? ~idx : idx, i.e. 2^ADDRW-1-idx on odd quadrants
  - sign = q[1]
- **ROM contents:** entry i = round((2^WIDTH-1)·sin((i+0.5)·π/2^(ADDRW+1))). The half-LSB offset makes the mirror symmetric with no duplicated sample.
- **Output stage:**
  - When en=1 (including clr=1 with en=1): sample <= sign ? −zext(rom_data) : zext(rom_data), zero-extended to WIDTH+1 bits. The sample is computed from the pre-update phase.
  - sample_valid <= en.
  - When en=0, sample holds its value.
- **Arithmetic:** negation is in WIDTH+1 bits and cannot overflow, since the magnitude is ≤ 2^WIDTH−1. Phase bits below the ROM index are truncated, with no dithering.

## Timing
- **Reset values:** phase=0, ftw=0, sample=0, sample_valid=0, wrap=0. rom_addr=0 follows from phase=0.
- **Latency:** the sample for phase value P appears on the cycle after P is present in the phase register with en=1. en to sample_valid is 1 cycle.
- **Throughput:** one sample per cycle with en held high.
- **wrap:** asserts in the cycle after the edge at which phase rolled over, aligned with sample_valid for that step's sample.
- **Mid-operation reset:** rst asserted while en=1 clears phase, ftw and all outputs at the next edge. No stale sample_valid follows.
- **rom_addr:** purely combinational from phase; the ROM read path must close in one cycle.

## Structure
- Package sine_dds_pkg holds:
  - typedef quadrant_t: enum {Q0_RISE, Q1_FALL, Q2_NEG_FALL, Q3_NEG_RISE}, 2 bits.
  - Default localparams for PHASE_W, ADDRW and WIDTH.
- Sub-module dds_phase_acc (phase register, ftw register, clr/en priority, wrap).
- The top level holds the folding logic and the output register.

## Test plan
All scenarios use PHASE_W=16, ADDRW=8, WIDTH=8 with a golden ROM model.

1. **Reset:** hold rst 3 cycles with en=1 and ftw_in=0x0040 loaded → sample=0, sample_valid=0, wrap=0 and rom_addr=0 throughout.
2. **Full-wave sweep:** load ftw=0x0040, then en=1 for 1024 cycles →
   - rom_addr runs 0..255 during phase 0x0000–0x3FC0, then 255..0 through the second quadrant.
   - sample is positive in the first half and negated in the second.
   - wrap pulses exactly once, on cycle 1024.
3. **Wrap mid-word:** ftw=0xC000 from phase 0 → phase 0xC000, 0x8000, 0x4000, 0x0000. wrap=1 on steps 2–4, 0 on step 1.
4. **Clear vs en:** clr=1 and en=1 in the same cycle at phase 0x1234 → phase=0, wrap=0. sample_valid=1 and sample is computed from phase 0x1234.
5. **Tuning word timing:** ftw_load with ftw_in=0x0100 while en=1 and ftw=0x0040 → the first step adds 0x0040 and the next adds 0x0100.
6. **en gaps:** toggle en 1,0,0,1 → phase and sample hold during the gaps, sample_valid=1,0,0,1, and there is no spurious wrap.
